// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD write scheduler.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_GAP
  } state_e;

  // One latched LCD write: register select plus data byte.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_wr_t;

  localparam logic [7:0] FUNC_SET   = 8'h3C;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] ENTRY_MODE = 8'h06;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] HOME       = 8'h02;

  localparam logic [7:0] CHAR_0     = 8'h30;
  localparam logic [7:0] CHAR_PLUS  = 8'h2B;
  localparam logic [7:0] CHAR_MINUS = 8'h2D;
  localparam logic [7:0] CHAR_EQ    = 8'h3D;
  localparam logic [7:0] CHAR_BLANK = 8'h20;

  localparam int unsigned INIT_LEN = 4;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY_MODE;
      default: return CLEAR;
    endcase
  endfunction

  function automatic logic [7:0] char_digit(input logic [3:0] d);
    return 8'(CHAR_0 + {4'b0000, d});
  endfunction

  // Clear and home need the long settle time; everything else the short gap.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CLEAR || data == HOME);
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter; a requester whose ack is showing is masked out.
module lcd_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic [1:0] ack_i,
  input  logic       accept_i,
  output logic       gnt_vld_c_o,
  output logic       gnt_idx_c_o
);

  logic       ptr_q, ptr_d;
  logic [1:0] elig;

  always_comb begin
    elig        = req_i & ~ack_i;
    gnt_vld_c_o = |elig;
    gnt_idx_c_o = elig[1] && (!elig[0] || ptr_q);
    ptr_d       = ptr_q;
    if (accept_i && gnt_vld_c_o) ptr_d = ~gnt_idx_c_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Owns the LCD bus: power-up init, then round-robin serialised writes with
// setup / enable / hold / busy-gap timing derived from the system clock.
module lcd_write_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned T_SU    = 2,
  parameter int unsigned T_EH    = 4,
  parameter int unsigned T_HD    = 2,
  parameter int unsigned GAP     = 40,
  parameter int unsigned CLR_GAP = 1600,
  parameter int unsigned PWR_CYC = 1000,
  parameter int unsigned CW      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  req_rs,
  input  logic [15:0] req_data,
  output logic [1:0]  ack,
  output logic        ready,
  output logic        busy,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data
);

  localparam logic [CW-1:0] LD_PWR  = CW'(PWR_CYC - 1);
  localparam logic [CW-1:0] LD_SU   = CW'(T_SU - 1);
  localparam logic [CW-1:0] LD_EH   = CW'(T_EH - 1);
  localparam logic [CW-1:0] LD_HD   = CW'(T_HD - 1);
  localparam logic [CW-1:0] LD_GAP  = CW'(GAP - 1);
  localparam logic [CW-1:0] LD_CLR  = CW'(CLR_GAP - 1);
  localparam logic [1:0]    INIT_LAST = 2'(INIT_LEN - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic [1:0]    init_idx_q, init_idx_d;
  logic          gidx_q, gidx_d;
  lcd_wr_t       wr_q, wr_d;
  logic          lcd_e_q, lcd_e_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic [1:0]    ack_q, ack_d;
  logic          gnt_vld, gnt_idx;
  logic          tmr_done;

  lcd_rr_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .ack_i       (ack_q),
    .accept_i    (state_q == ST_IDLE),
    .gnt_vld_c_o (gnt_vld),
    .gnt_idx_c_o (gnt_idx)
  );

  // Next-state: every state entry reloads the timer, otherwise it counts to zero and holds.
  always_comb begin
    tmr_done   = (tmr_q == '0);
    state_d    = state_q;
    tmr_d      = tmr_done ? tmr_q : tmr_q - CW'(1);
    init_idx_d = init_idx_q;
    gidx_d     = gidx_q;
    wr_d       = wr_q;
    lcd_e_d    = lcd_e_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    ack_d      = 2'b00;

    case (state_q)
      ST_PWR_WAIT: begin
        if (tmr_done) state_d = ST_INIT;
      end
      ST_INIT: begin
        wr_d    = '{rs: 1'b0, data: init_cmd(init_idx_q)};
        state_d = ST_SETUP;
        tmr_d   = LD_SU;
      end
      ST_IDLE: begin
        busy_d = 1'b0;
        if (gnt_vld) begin
          gidx_d  = gnt_idx;
          wr_d    = '{rs: req_rs[gnt_idx], data: (gnt_idx ? req_data[15:8] : req_data[7:0])};
          state_d = ST_SETUP;
          tmr_d   = LD_SU;
          busy_d  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d = ST_E_HIGH;
          lcd_e_d = 1'b1;
          tmr_d   = LD_EH;
        end
      end
      ST_E_HIGH: begin
        if (tmr_done) begin
          state_d = ST_HOLD;
          lcd_e_d = 1'b0;
          tmr_d   = LD_HD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          state_d = ST_GAP;
          tmr_d   = is_slow_cmd(wr_q.rs, wr_q.data) ? LD_CLR : LD_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          if (!ready_q) begin
            if (init_idx_q == INIT_LAST) begin
              state_d = ST_IDLE;
              ready_d = 1'b1;
              busy_d  = 1'b0;
            end else begin
              init_idx_d = init_idx_q + 2'd1;
              state_d    = ST_INIT;
            end
          end else begin
            ack_d[gidx_q] = 1'b1;
            state_d       = ST_IDLE;
            busy_d        = 1'b0;
          end
        end
      end
      default: state_d = ST_PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_PWR_WAIT;
      tmr_q      <= LD_PWR;
      init_idx_q <= 2'd0;
      gidx_q     <= 1'b0;
      wr_q       <= '0;
      lcd_e_q    <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
      ack_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      init_idx_q <= init_idx_d;
      gidx_q     <= gidx_d;
      wr_q       <= wr_d;
      lcd_e_q    <= lcd_e_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
    end
  end

  assign ack      = ack_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign lcd_e    = lcd_e_q;
  assign lcd_rs   = wr_q.rs;
  assign lcd_data = wr_q.data;
  assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Directed bench for lcd_write_scheduler: scoreboard of expected writes popped on ack,
// plus cycle-exact latency checks against the default timing parameters.
module tb_lcd_write_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  req_rs;
  logic [15:0] req_data;
  logic [1:0]  ack;
  logic        ready;
  logic        busy;
  logic        lcd_e;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;

  typedef struct {
    logic [1:0] ack;
    logic       rs;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] init_tab [4] = '{8'h3C, 8'h0C, 8'h06, 8'h01};

  lcd_write_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_rs   (req_rs),
    .req_data (req_data),
    .ack      (ack),
    .ready    (ready),
    .busy     (busy),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_data (lcd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic [1:0] a, input logic rs, input logic [7:0] d);
    exp_t e;
    e.ack = a; e.rs = rs; e.data = d;
    sb.push_back(e);
  endtask

  // Returns number of negedges until ack is seen (-1 on timeout).
  task automatic wait_ack(input int budget, output int k, output logic [1:0] a);
    k = -1;
    a = 2'b00;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        k = i;
        a = ack;
        break;
      end
    end
    if (k < 0) chk("ack_timeout", 32'(ack), 32'h1);
  endtask

  // Waits for an lcd_e pulse; returns its width, rs/data at the rise; stops on the fall negedge.
  task automatic wait_pulse(input int budget, output int w, output logic rs, output logic [7:0] d);
    bit seen = 1'b0;
    w = 0; rs = 1'b0; d = 8'h00;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (lcd_e) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      chk("pulse_timeout", 32'(lcd_e), 32'h1);
    end else begin
      rs = lcd_rs;
      d  = lcd_data;
      w  = 1;
      for (int i = 0; i < budget; i++) begin
        @(negedge clk);
        if (lcd_e) w++;
        else break;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("idle_wait", 32'(busy), 32'h0);
  endtask

  // Scoreboard monitor: capture each write at the rise of lcd_e, compare on ack.
  logic       e_prev = 1'b0;
  logic [1:0] ack_prev = 2'b00;
  logic       cap_rs = 1'b0;
  logic [7:0] cap_data = 8'h00;
  int         e_w = 0;
  int         cap_w = 0;

  always @(negedge clk) begin
    if (rst) begin
      e_prev   = 1'b0;
      ack_prev = 2'b00;
      e_w      = 0;
    end else begin
      if (lcd_e && !e_prev) begin
        cap_rs   = lcd_rs;
        cap_data = lcd_data;
        e_w      = 0;
      end
      if (lcd_e) e_w++;
      if (!lcd_e && e_prev) cap_w = e_w;
      if (ack != 2'b00) begin
        chk("ack_while_ready", 32'(ready), 32'h1);
        chk("ack_one_cycle", 32'(ack_prev), 32'h0);
        chk("ack_onehot", 32'($onehot(ack)), 32'h1);
        if (sb.size() == 0) begin
          chk("ack_unexpected", 32'(ack), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_ack_idx", 32'(ack), 32'(e.ack));
          chk("sb_lcd_rs", 32'(cap_rs), 32'(e.rs));
          chk("sb_lcd_data", 32'(cap_data), 32'(e.data));
          chk("sb_e_width", 32'(cap_w), 32'd4);
        end
      end
      e_prev   = lcd_e;
      ack_prev = ack;
    end
  end

  initial begin
    int         w, k, n, e_hi, acks, first_e, sec_e, ack_k;
    logic       rs, e_last;
    logic [7:0] d;
    logic [1:0] a;
    logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    rst = 1'b1; req = 2'b00; req_rs = 2'b00; req_data = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_lcd_e", 32'(lcd_e), 32'h0);
    chk("rst_lcd_rs", 32'(lcd_rs), 32'h0);
    chk("rst_lcd_rw", 32'(lcd_rw), 32'h0);
    chk("rst_lcd_data", 32'(lcd_data), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    rst = 1'b0;

    // Power-up wait: no enable activity for PWR_CYC cycles.
    e_hi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (lcd_e) e_hi++;
    end
    chk("pwr_wait_e_low", 32'(e_hi), 32'h0);

    for (int i = 0; i < 4; i++) begin
      wait_pulse(3000, w, rs, d);
      chk("init_data", 32'(d), 32'(init_tab[i]));
      chk("init_rs", 32'(rs), 32'h0);
      chk("init_e_width", 32'(w), 32'd4);
      if (i < 3) chk("init_not_ready", 32'(ready), 32'h0);
    end
    // Clear: HOLD (2) + CLR_GAP (1600) from the lcd_e fall to ready.
    n = 0;
    for (int i = 1; i <= 2000; i++) begin
      if (ready) break;
      @(negedge clk);
      n = i;
    end
    chk("init_clr_gap", 32'(n), 32'd1602);
    chk("ready_after_init", 32'(ready), 32'h1);
    chk("busy_after_init", 32'(busy), 32'h0);
    chk("rw_after_init", 32'(lcd_rw), 32'h0);

    // Uncontended requester 0, held: ack at 49, second grant's enable at 53.
    @(negedge clk);
    req_rs = 2'b01; req_data = 16'h0035; req = 2'b01;
    push_exp(2'b01, 1'b1, 8'h35);
    push_exp(2'b01, 1'b1, 8'h35);
    first_e = -1; sec_e = -1; ack_k = -1; acks = 0; e_last = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) chk("busy_after_grant", 32'(busy), 32'h1);
      if (lcd_e && !e_last) begin
        if (first_e < 0) first_e = i;
        else if (sec_e < 0) sec_e = i;
      end
      e_last = lcd_e;
      if (i == 3) begin
        chk("u_lcd_data", 32'(lcd_data), 32'h35);
        chk("u_lcd_rs", 32'(lcd_rs), 32'h1);
      end
      if (i == 7) chk("u_e_fall", 32'(lcd_e), 32'h0);
      if (ack != 2'b00) begin
        acks++;
        if (ack_k < 0) ack_k = i;
      end
      if (i == 51) req = 2'b00;
    end
    chk("u_first_e_rise", 32'(first_e), 32'd3);
    chk("u_ack_cycle", 32'(ack_k), 32'd49);
    chk("u_ack_count", 32'(acks), 32'd1);
    chk("u_second_e_rise", 32'(sec_e), 32'd53);
    wait_ack(200, k, a);
    chk("u_second_ack", 32'(k + 60), 32'd99);
    wait_idle(100);

    // Requester 1 clear: long gap.
    @(negedge clk);
    req_rs = 2'b00; req_data = 16'h0100; req = 2'b10;
    push_exp(2'b10, 1'b0, 8'h01);
    @(negedge clk);
    req = 2'b00;
    wait_ack(3000, k, a);
    chk("clr_latency", 32'(k + 1), 32'd1609);
    chk("clr_ack_idx", 32'(a), 32'h2);
    wait_idle(100);

    // Same byte as data (rs=1): normal gap.
    @(negedge clk);
    req_rs = 2'b10; req_data = 16'h0100; req = 2'b10;
    push_exp(2'b10, 1'b1, 8'h01);
    @(negedge clk);
    req = 2'b00;
    wait_ack(300, k, a);
    chk("data01_latency", 32'(k + 1), 32'd49);
    wait_idle(100);

    // Both requesting with pointer at 0: 0,1,0,1 back-to-back.
    @(negedge clk);
    req_rs = 2'b11; req_data = 16'h3D2B; req = 2'b11;
    for (int i = 0; i < 4; i++) push_exp(rr_exp[i], 1'b1, rr_exp[i][0] ? 8'h2B : 8'h3D);
    for (int i = 0; i < 4; i++) begin
      wait_ack(300, k, a);
      chk("rr_order", 32'(a), 32'(rr_exp[i]));
      chk("rr_spacing", 32'(k), 32'd49);
      if (i == 2) req = 2'b10;
      if (i == 3) req = 2'b00;
    end
    wait_idle(100);

    // Requester changes data and drops req during E_HIGH: latched write unaffected.
    @(negedge clk);
    req_rs = 2'b01; req_data = 16'h0031; req = 2'b01;
    push_exp(2'b01, 1'b1, 8'h31);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 4) begin
        chk("latch_e_high", 32'(lcd_e), 32'h1);
        req_data = 16'h0039;
        req = 2'b00;
      end
      if (i == 5 || i == 8) chk("latch_data", 32'(lcd_data), 32'h31);
    end
    wait_ack(200, k, a);
    chk("latch_ack_cycle", 32'(k + 8), 32'd49);
    wait_idle(100);

    // Reset in E_HIGH: lcd_e drops immediately, no ack, init restarts.
    @(negedge clk);
    req_rs = 2'b01; req_data = 16'h0035; req = 2'b01;
    push_exp(2'b01, 1'b1, 8'h35);
    repeat (4) @(negedge clk);
    chk("pre_rst_e_high", 32'(lcd_e), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_e", 32'(lcd_e), 32'h0);
    chk("async_rst_ready", 32'(ready), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h1);
    chk("async_rst_data", 32'(lcd_data), 32'h0);
    req = 2'b00;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    e_hi = 0; acks = 0;
    repeat (1000) begin
      @(negedge clk);
      if (lcd_e) e_hi++;
      if (ack != 2'b00) acks++;
    end
    chk("rerst_e_low", 32'(e_hi), 32'h0);
    chk("rerst_no_ack", 32'(acks), 32'h0);
    chk("rerst_not_ready", 32'(ready), 32'h0);
    wait_pulse(3000, w, rs, d);
    chk("rerst_first_cmd", 32'(d), 32'h3C);
    chk("rerst_first_width", 32'(w), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
